alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue register feeding the ALU: decodes MIPS opcode/funct into the 4-bit ALU operation
//  code, builds operand A/B (immediate extension, shamt/LUI shift amounts, signed-SLT bias) and
//  presents them registered, with a 2-entry skid buffer and valid/ready handshakes on both sides.
//  Sits between decode and the ALU in the execute stage; op codes are the execute_constants.vh macros.
// PARAMETERS
//  NB        32  datapath width
//  NB_OP     4   ALU operation code width
//  NB_IMM    16  immediate width
//  NB_SHAMT  5   shift-amount width
// PORTS
//  i_clk        in   1         clock, all state on rising edge
//  i_reset      in   1         synchronous, active-low reset
//  i_valid      in   1         upstream instruction valid
//  o_ready      out  1         stage can accept (registered)
//  i_opcode     in   6         instr[31:26]
//  i_funct      in   6         instr[5:0]
//  i_shamt      in   NB_SHAMT  instr[10:6]
//  i_imm        in   NB_IMM    instr[15:0]
//  i_rs_data    in   NB        rs operand (post-forwarding)
//  i_rt_data    in   NB        rt operand (post-forwarding)
//  i_flush      in   1         drop all held and incoming entries
//  o_valid      out  1         ALU inputs valid
//  i_ready      in   1         ALU/EX-MEM accepts
//  o_data_a     out  NB        ALU operand A
//  o_data_b     out  NB        ALU operand B
//  o_operation  out  NB_OP     ALU operation code
//  o_illegal    out  1         held entry is an undecodable instruction
// BEHAVIOUR
//  - Transfer in: i_valid & o_ready; transfer out: o_valid & i_ready. Latency 1 cycle in->out.
//  - Occupancy FSM EMPTY/ONE/TWO: EMPTY -in-> ONE; ONE -in&!out-> TWO, -out&!in-> EMPTY, else ONE;
//    TWO -out-> ONE (no in: o_ready=0). o_ready = (state!=TWO), registered. Outputs from head entry.
//  - Entries captured fully decoded; output regs never change while o_valid & !i_ready.
//  - Reset (i_reset=0): state EMPTY, o_valid=0, o_ready=1, o_data_a/b=0, o_operation=`ADD, o_illegal=0.
//  - i_flush: next cycle state EMPTY, o_valid=0; same-cycle input dropped; flush wins over all.
//  - Decode, R-type (opcode 0) by funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR,
//    0x27 NOR, 0x2A SLT, 0x2B SLTU->SLT; A=rs, B=rt. 0x00 SLL, 0x02 SRL, 0x03 SRA: A=zext(shamt),
//    B=rt. 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: A=zext(rs[4:0]), B=rt.
//  - I-type: 0x08/0x09 ADD, A=rs, B=sext(imm); 0x0C AND, 0x0D OR, 0x0E XOR with B=zext(imm);
//    0x0A SLTI, 0x0B SLTIU -> SLT, B=sext(imm); 0x23 LW, 0x2B SW -> ADD, B=sext(imm);
//    0x04/0x05 BEQ/BNE -> SUB, A=rs, B=rt; 0x0F LUI -> SLL, A=16, B=zext(imm).
//  - ALU SLT compares unsigned: for signed SLT/SLTI both A and B have bit NB-1 inverted before
//    capture; SLTU/SLTIU pass unmodified.
//  - Unknown opcode/funct: handled per CONFIGURATION; still flows through handshake as one entry.
// CONFIGURATION
//  ALU_ISSUE_ILLEGAL_TRAP_EN defined: unknown instr -> o_operation=`AND, A=B=0, o_illegal=1 on
//    that entry (result 0, o_cero=1 at ALU).
//  Undefined: unknown instr -> o_operation=`ADD, A=B=0; o_illegal constant 0.
// TESTING
//  1 ADD R: rs=5, rt=7, funct 0x20, i_ready=1 -> next cycle o_valid=1, A=5, B=7, op=`ADD.
//  2 SLTI rs=0xFFFF_FFFF, imm=0x0001 -> A=0x7FFF_FFFF, B=0x8000_0001, op=`SLT (ALU gives 1).
//  3 LUI imm=0x1234 -> A=16, B=0x0000_1234, op=`SLL; ORI imm=0x8000 -> B=0x0000_8000.
//  4 Back-pressure: i_ready=0, issue 3 back-to-back -> o_ready low after 2 accepted, 3rd held
//    upstream; release i_ready -> entries leave in order, outputs stable while stalled.
//  5 Flush with TWO occupied + i_valid=1 -> next cycle o_valid=0, o_ready=1, nothing emerges.
//  6 opcode 0x3F: with ILLEGAL_TRAP_EN -> o_illegal=1, op=`AND; without -> o_illegal=0, op=`ADD;
//    reset asserted mid-stall -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus for the ID/EX ALU issue register.
// slave: the issue stage itself; master: the decode/ALU side driving it.
interface alu_issue_stage_if #(
    parameter int NB       = 32,
    parameter int NB_OP    = 4,
    parameter int NB_IMM   = 16,
    parameter int NB_SHAMT = 5
);
    logic                i_valid;
    logic                o_ready;
    logic [5:0]          i_opcode;
    logic [5:0]          i_funct;
    logic [NB_SHAMT-1:0] i_shamt;
    logic [NB_IMM-1:0]   i_imm;
    logic [NB-1:0]       i_rs_data;
    logic [NB-1:0]       i_rt_data;
    logic                i_flush;
    logic                o_valid;
    logic                i_ready;
    logic [NB-1:0]       o_data_a;
    logic [NB-1:0]       o_data_b;
    logic [NB_OP-1:0]    o_operation;
    logic                o_illegal;

    modport slave (
        input  i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
        input  i_flush, i_ready,
        output o_ready, o_valid, o_data_a, o_data_b, o_operation, o_illegal
    );

    modport master (
        output i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
        output i_flush, i_ready,
        input  o_ready, o_valid, o_data_a, o_data_b, o_operation, o_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU: decodes opcode/funct into an ALU op,
// builds operands A/B and holds up to two decoded entries (skid buffer).
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN (undecodable instructions
// become AND 0,0 with o_illegal set; otherwise ADD 0,0 with o_illegal=0).
`ifndef AND
`define AND 4'b0000
`endif
`ifndef OR
`define OR  4'b0001
`endif
`ifndef ADD
`define ADD 4'b0010
`endif
`ifndef SUB
`define SUB 4'b0110
`endif
`ifndef SLT
`define SLT 4'b0111
`endif
`ifndef SLL
`define SLL 4'b1000
`endif
`ifndef SRL
`define SRL 4'b1001
`endif
`ifndef SRA
`define SRA 4'b1010
`endif
`ifndef NOR
`define NOR 4'b1100
`endif
`ifndef XOR
`define XOR 4'b1101
`endif

module alu_issue_stage #(
    parameter int NB       = 32,
    parameter int NB_OP    = 4,
    parameter int NB_IMM   = 16,
    parameter int NB_SHAMT = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    alu_issue_stage_if.slave  bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic             illegal;
        logic [NB_OP-1:0] op;
        logic [NB-1:0]    a;
        logic [NB-1:0]    b;
    } entry_t;

    localparam logic [NB-1:0] SIGN_BIAS = {1'b1, {(NB-1){1'b0}}};

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;
    entry_t dec;
    logic   known;

    logic [NB-1:0] sext_imm, zext_imm, zext_shamt, zext_rs_sh;

    assign sext_imm   = {{(NB-NB_IMM){bus.i_imm[NB_IMM-1]}}, bus.i_imm};
    assign zext_imm   = {{(NB-NB_IMM){1'b0}}, bus.i_imm};
    assign zext_shamt = {{(NB-NB_SHAMT){1'b0}}, bus.i_shamt};
    assign zext_rs_sh = {{(NB-NB_SHAMT){1'b0}}, bus.i_rs_data[NB_SHAMT-1:0]};

    // Decode the incoming instruction into a complete ALU entry.
    // Signed compares are mapped onto the unsigned ALU SLT by flipping both MSBs.
    always_comb begin
        dec         = '0;
        dec.op      = `ADD;
        dec.a       = bus.i_rs_data;
        dec.b       = bus.i_rt_data;
        known       = 1'b1;
        case (bus.i_opcode)
            6'h00: begin
                case (bus.i_funct)
                    6'h20, 6'h21: dec.op = `ADD;
                    6'h22, 6'h23: dec.op = `SUB;
                    6'h24:        dec.op = `AND;
                    6'h25:        dec.op = `OR;
                    6'h26:        dec.op = `XOR;
                    6'h27:        dec.op = `NOR;
                    6'h2A: begin
                        dec.op = `SLT;
                        dec.a  = bus.i_rs_data ^ SIGN_BIAS;
                        dec.b  = bus.i_rt_data ^ SIGN_BIAS;
                    end
                    6'h2B:        dec.op = `SLT;
                    6'h00: begin dec.op = `SLL; dec.a = zext_shamt; end
                    6'h02: begin dec.op = `SRL; dec.a = zext_shamt; end
                    6'h03: begin dec.op = `SRA; dec.a = zext_shamt; end
                    6'h04: begin dec.op = `SLL; dec.a = zext_rs_sh; end
                    6'h06: begin dec.op = `SRL; dec.a = zext_rs_sh; end
                    6'h07: begin dec.op = `SRA; dec.a = zext_rs_sh; end
                    default:      known  = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin dec.op = `ADD; dec.b = sext_imm; end
            6'h0C: begin dec.op = `AND; dec.b = zext_imm; end
            6'h0D: begin dec.op = `OR;  dec.b = zext_imm; end
            6'h0E: begin dec.op = `XOR; dec.b = zext_imm; end
            6'h0A: begin
                dec.op = `SLT;
                dec.a  = bus.i_rs_data ^ SIGN_BIAS;
                dec.b  = sext_imm ^ SIGN_BIAS;
            end
            6'h0B: begin dec.op = `SLT; dec.b = sext_imm; end
            6'h04, 6'h05: dec.op = `SUB;
            6'h0F: begin
                dec.op = `SLL;
                dec.a  = NB'(NB_IMM);
                dec.b  = zext_imm;
            end
            default: known = 1'b0;
        endcase
        if (!known) begin
            dec.a = '0;
            dec.b = '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            dec.op      = `AND;
            dec.illegal = 1'b1;
`else
            dec.op      = `ADD;
            dec.illegal = 1'b0;
`endif
        end
    end

    logic in_fire, out_fire;
    assign in_fire  = bus.i_valid & ready_q;
    assign out_fire = valid_q & bus.i_ready;

    // Occupancy FSM and entry movement; head entry drives the outputs directly.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d = ST_ONE;
                    head_d  = dec;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = dec;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = dec;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (out_fire) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    // State and entry registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            head_q.op   <= `ADD;
            skid_q      <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_data_a    = head_q.a;
    assign bus.o_data_b    = head_q.b;
    assign bus.o_operation = head_q.op;
    assign bus.o_illegal   = head_q.illegal;
endmodule
